// File: rtl/pb_event_scheduler.sv
// rtl/pb_event_scheduler.sv - round-robin scheduler of debounced push-button press events
//
// Purpose: detects the rising edge of each debounced button, keeps at most one
// pending event per button and offers them one at a time, round-robin, on a
// valid/ready port.
// Optional feature macro: PB_AUTO_REPEAT_EN (held buttons re-fire every
// REPEAT_CYCLES clocks).
//
// Ports:
//   clock         system clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   pb_debounced  debounced button levels, bit i = button i, active-high
//   evt_valid     event offered to consumer
//   evt_id        index of the button whose event is offered
//   evt_ready     consumer accepts the offered event
//   evt_drop      sticky flag: a press was lost because its button was already pending
//   drop_clr      clears evt_drop (a new drop in the same cycle wins)
module pb_event_scheduler #(
    parameter int N_BTN         = 4,
    parameter int ID_W          = 2,
    parameter int REPEAT_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  pb_debounced,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    input  logic              evt_ready,
    output logic              evt_drop,
    input  logic              drop_clr
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    if (N_BTN < 2 || N_BTN > 16 || (1 << ID_W) < N_BTN || REPEAT_CYCLES < 2) begin : g_param_check
        $error("pb_event_scheduler: illegal parameter combination");
    end

    logic [0:0]       state;
    logic [N_BTN-1:0] pb_delay;
    logic [N_BTN-1:0] pending;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_BTN-1:0] real_edge;
    logic [N_BTN-1:0] pb_edge;
    logic [ID_W-1:0]  winner;
    logic [N_BTN-1:0] load_mask;
    logic [N_BTN-1:0] pending_nxt;
    logic             take;
    logic             release_offer;
    logic             drop_hit;

    // pb_delay resets to all ones so a button held through reset does not fire.
    assign real_edge = pb_debounced & ~pb_delay;

`ifdef PB_AUTO_REPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt [N_BTN];
    logic [N_BTN-1:0] rpt_edge;

    always_comb begin
        rpt_edge = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_edge[i] = pb_debounced[i] & (hold_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!pb_debounced[i] || real_edge[i] || hold_cnt[i] == CNT_MAX) begin
                    hold_cnt[i] <= '0;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pb_edge = real_edge | rpt_edge;
`else
    assign pb_edge = real_edge;
`endif

    // Winner: first pending bit after rr_ptr, wrapping. Walking the search order
    // backwards lets the earliest hit overwrite later ones.
    always_comb begin
        logic [ID_W-1:0] idx;
        winner = '0;
        idx    = '0;
        for (int k = N_BTN; k >= 1; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_BTN);
            if (pending[idx]) winner = idx;
        end
    end

    // In OFFER the offered event is already out of pending, so |pending means
    // another event can follow back-to-back on acceptance.
    always_comb begin
        take          = (|pending) && (state == IDLE || evt_ready);
        release_offer = (state == OFFER) && evt_ready && !(|pending);
        load_mask     = '0;
        if (take) load_mask[winner] = 1'b1;
        // A new edge on the button being loaded re-queues it instead of dropping.
        pending_nxt   = (pending & ~load_mask) | pb_edge;
        drop_hit      = |(pb_edge & pending & ~load_mask);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pb_delay  <= '1;
            pending   <= '0;
            rr_ptr    <= ID_W'(N_BTN - 1);
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_drop  <= 1'b0;
        end else begin
            pb_delay <= pb_debounced;
            pending  <= pending_nxt;
            if (drop_hit) begin
                evt_drop <= 1'b1;
            end else if (drop_clr) begin
                evt_drop <= 1'b0;
            end
            if (take) begin
                evt_id    <= winner;
                evt_valid <= 1'b1;
                rr_ptr    <= winner;
                state     <= OFFER;
            end else if (release_offer) begin
                evt_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pb_event_scheduler.sv
// tb/tb_pb_event_scheduler.sv - directed self-checking bench for pb_event_scheduler
module tb_pb_event_scheduler;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [3:0] pb_debounced;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       evt_drop;
    logic       drop_clr;

    int tests_run = 0;
    int tests_failed = 0;
    int evt_count;

    always #5 clock = ~clock;

    pb_event_scheduler #(
        .N_BTN(4),
        .ID_W(2),
        .REPEAT_CYCLES(8)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .pb_debounced(pb_debounced),
        .evt_valid(evt_valid),
        .evt_id(evt_id),
        .evt_ready(evt_ready),
        .evt_drop(evt_drop),
        .drop_clr(drop_clr)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // 1: button held through reset gives no event
        rst_n = 1'b0; pb_debounced = 4'b0001; evt_ready = 1'b0; drop_clr = 1'b0;
        step(); step();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_drop", 32'(evt_drop), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1_no_poweron_evt", 32'(evt_valid), 32'd0);
        end
        pb_debounced = 4'b0000;
        step();

        // 2: single press, 2-clock latency, single-cycle offer
        evt_ready = 1'b1; pb_debounced = 4'b0100;
        step();
        pb_debounced = 4'b0000;
        check("t2_lat1_valid", 32'(evt_valid), 32'd0);
        step();
        check("t2_valid", 32'(evt_valid), 32'd1);
        check("t2_id", 32'(evt_id), 32'd2);
        step();
        check("t2_done", 32'(evt_valid), 32'd0);

        // 3: simultaneous presses drained round-robin from ptr=3
        do_reset();
        pb_debounced = 4'b1111;
        step();
        check("t3_lat", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_sweep_valid", 32'(evt_valid), 32'd1);
            check("t3_sweep_id", 32'(evt_id), 32'(i));
        end
        step();
        check("t3_sweep_end", 32'(evt_valid), 32'd0);
        pb_debounced = 4'b0000;
        step();
        pb_debounced = 4'b1010;
        step();
        pb_debounced = 4'b0000;
        step();
        check("t3_b_first", 32'(evt_id), 32'd1);
        check("t3_b_first_v", 32'(evt_valid), 32'd1);
        step();
        check("t3_b_second", 32'(evt_id), 32'd3);
        step();
        check("t3_b_end", 32'(evt_valid), 32'd0);

        // 4: stalled consumer, third press on btn1 drops
        evt_ready = 1'b0;
        pb_debounced = 4'b0010; step();
        pb_debounced = 4'b0000; step();
        check("t4_offer_v", 32'(evt_valid), 32'd1);
        check("t4_offer_id", 32'(evt_id), 32'd1);
        pb_debounced = 4'b0010; step();
        check("t4_queued_nodrop", 32'(evt_drop), 32'd0);
        pb_debounced = 4'b0000; step();
        pb_debounced = 4'b0010; step();
        check("t4_drop", 32'(evt_drop), 32'd1);
        check("t4_id_stable", 32'(evt_id), 32'd1);
        check("t4_v_stable", 32'(evt_valid), 32'd1);
        pb_debounced = 4'b0000; drop_clr = 1'b1; step();
        drop_clr = 1'b0;
        check("t4_drop_clr", 32'(evt_drop), 32'd0);
        evt_ready = 1'b1; step();
        check("t4_b2b_v", 32'(evt_valid), 32'd1);
        check("t4_b2b_id", 32'(evt_id), 32'd1);
        step();
        check("t4_end", 32'(evt_valid), 32'd0);

        // 5: re-press of the offered button is re-queued; drop set beats clear
        evt_ready = 1'b0;
        pb_debounced = 4'b0001; step();
        pb_debounced = 4'b0000; step();
        check("t5_offer_id", 32'(evt_id), 32'd0);
        pb_debounced = 4'b0001; step();
        check("t5_requeue_nodrop", 32'(evt_drop), 32'd0);
        pb_debounced = 4'b0000; step();
        pb_debounced = 4'b0001; drop_clr = 1'b1; step();
        check("t5_set_wins", 32'(evt_drop), 32'd1);
        pb_debounced = 4'b0000; step();
        drop_clr = 1'b0;
        check("t5_clr", 32'(evt_drop), 32'd0);
        evt_ready = 1'b1; step();
        check("t5_again_v", 32'(evt_valid), 32'd1);
        check("t5_again_id", 32'(evt_id), 32'd0);
        step();
        check("t5_end", 32'(evt_valid), 32'd0);
        check("t5_end_drop", 32'(evt_drop), 32'd0);

        // async reset mid-offer discards offered and pending events
        evt_ready = 1'b0;
        pb_debounced = 4'b1000; step();
        pb_debounced = 4'b0000; step();
        check("ar_offer_id", 32'(evt_id), 32'd3);
        pb_debounced = 4'b0100; step();
        pb_debounced = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("ar_async_valid", 32'(evt_valid), 32'd0);
        check("ar_async_id", 32'(evt_id), 32'd0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check("ar_pending_gone", 32'(evt_valid), 32'd0);

        // 6: hold btn3 for 30 clocks
        evt_ready = 1'b1; evt_count = 0;
        pb_debounced = 4'b1000;
        for (int i = 0; i < 30; i++) begin
            step();
            if (evt_valid && evt_ready) evt_count++;
        end
        pb_debounced = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            if (evt_valid && evt_ready) evt_count++;
        end
`ifdef PB_AUTO_REPEAT_EN
        check("t6_repeat_count", 32'(evt_count), 32'd4);
`else
        check("t6_single_count", 32'(evt_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
